// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO in front of the serialiser.
// Words are accepted over a valid/ready handshake, buffered, and sent
// LSB-first with optional even/odd parity and one or two stop bits. The
// parity mode and stop-bit count are captured when a word leaves the FIFO,
// so later changes on those inputs only affect later frames.
module uart_tx_fifo #(
    parameter int PAYLOAD_BITS = 8,
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 115200,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    output logic                               uart_txd,
    input  logic [PAYLOAD_BITS-1:0]            tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    input  logic [1:0]                         parity_mode,
    input  logic                               two_stop,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               uart_tx_busy
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int CYC_W          = $clog2(CYCLES_PER_BIT + 1);
    localparam int PTR_W          = $clog2(FIFO_DEPTH);
    localparam int CNT_W          = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W          = $clog2(PAYLOAD_BITS);

    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(CYCLES_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BITS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PAYLOAD_BITS-1:0] head_word;
    logic                    push;
    logic                    pop;
    logic                    fifo_empty;
    logic                    bit_done;
    logic                    last_stop;

    state_t                  state;
    logic [CYC_W-1:0]        cyc_cnt;
    logic [IDX_W-1:0]        bit_idx;
    logic [PAYLOAD_BITS-1:0] shift_reg;
    logic                    parity_bit;
    logic                    parity_en;
    logic                    two_stop_q;
    logic                    stop_idx;
    logic                    line_bit;

    assign fifo_empty   = (fifo_count == '0);
    assign tx_ready     = (fifo_count != FULL_CNT);
    assign push         = tx_valid && tx_ready;
    assign head_word    = mem[rd_ptr];
    assign bit_done     = (cyc_cnt == LAST_CYC);
    assign last_stop    = bit_done && (stop_idx || !two_stop_q);
    assign pop          = !fifo_empty && ((state == IDLE) || ((state == STOP) && last_stop));
    assign uart_tx_busy = (state != IDLE) || !fifo_empty;

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; a push and pop together leave the count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Frame sequencer: picks the line level for each bit period and captures the next word
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            parity_en  <= 1'b0;
            two_stop_q <= 1'b0;
            stop_idx   <= 1'b0;
            line_bit   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    line_bit <= 1'b1;
                    cyc_cnt  <= '0;
                    if (pop) begin
                        state <= START;
                    end
                end
                START: begin
                    line_bit <= 1'b0;
                    if (bit_done) begin
                        cyc_cnt <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                    end
                end
                DATA: begin
                    line_bit <= shift_reg[0];
                    if (bit_done) begin
                        cyc_cnt   <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == LAST_IDX) begin
                            state <= parity_en ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                    end
                end
                PARITY: begin
                    line_bit <= parity_bit;
                    if (bit_done) begin
                        cyc_cnt <= '0;
                        state   <= STOP;
                    end else begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                    end
                end
                STOP: begin
                    line_bit <= 1'b1;
                    if (bit_done) begin
                        cyc_cnt <= '0;
                        if (!last_stop) begin
                            stop_idx <= 1'b1;
                        end else begin
                            state <= pop ? START : IDLE;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CYC_W'(1);
                    end
                end
                default: begin
                    line_bit <= 1'b1;
                    state    <= IDLE;
                end
            endcase

            if (pop) begin
                shift_reg  <= head_word;
                parity_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                parity_bit <= (^head_word) ^ (parity_mode == 2'b10);
                two_stop_q <= two_stop;
                stop_idx   <= 1'b0;
            end
        end
    end

    // Output register so the serial line never glitches; forced high on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            uart_txd <= 1'b1;
        end else begin
            uart_txd <= line_bit;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: table-driven frame checks, hand-written
// sequences for backpressure, stop-bit changes and mid-frame reset, a wide
// default-rate build, and a randomised run against a timing-level model.
module tb_uart_tx_fifo;

    localparam int C     = 10;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic       uart_txd;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [1:0] parity_mode;
    logic       two_stop;
    logic [2:0] fifo_count;
    logic       uart_tx_busy;

    logic       txd9;
    logic [8:0] tx_data9;
    logic       tx_valid9;
    logic       tx_ready9;
    logic [2:0] fifo_count9;
    logic       busy9;

    int errors = 0;
    int checks = 0;

    uart_tx_fifo #(
        .PAYLOAD_BITS(8),
        .CLK_HZ      (1_000_000),
        .BIT_RATE    (100_000),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .uart_txd    (uart_txd),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .fifo_count  (fifo_count),
        .uart_tx_busy(uart_tx_busy)
    );

    uart_tx_fifo #(
        .PAYLOAD_BITS(9)
    ) dut9 (
        .clk         (clk),
        .reset       (reset),
        .uart_txd    (txd9),
        .tx_data     (tx_data9),
        .tx_valid    (tx_valid9),
        .tx_ready    (tx_ready9),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .fifo_count  (fifo_count9),
        .uart_tx_busy(busy9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: words wait in a queue; a frame may start once the previous
    // frame's bit periods have all elapsed, and its line bits appear two edges later.
    int         cyc        = 0;
    int         busy_until = 0;
    logic [7:0] mq[$];
    bit         exp_line[$];
    bit         exp_txd    = 1'b1;

    function automatic void addBit(input bit b);
        for (int i = 0; i < C; i++) exp_line.push_back(b);
    endfunction

    always @(posedge clk) begin : model_update
        logic [7:0] w;
        int         nbits;
        bit         do_pop;
        bit         do_push;
        cyc = cyc + 1;
        if (reset) begin
            mq.delete();
            exp_line.delete();
            exp_txd    = 1'b1;
            busy_until = 0;
        end else begin
            if (exp_line.size() > 0) exp_txd = exp_line.pop_front();
            else exp_txd = 1'b1;
            do_pop  = (mq.size() > 0) && (cyc >= busy_until);
            do_push = tx_valid && (mq.size() != DEPTH);
            if (do_pop) begin
                w = mq.pop_front();
                if (exp_line.size() == 0) exp_line.push_back(1'b1);
                addBit(1'b0);
                for (int i = 0; i < 8; i++) addBit(w[i]);
                nbits = 9;
                if (parity_mode == 2'b01 || parity_mode == 2'b10) begin
                    addBit((($countones(w) % 2) == 1) ^ (parity_mode == 2'b10));
                    nbits++;
                end
                addBit(1'b1);
                nbits++;
                if (two_stop) begin
                    addBit(1'b1);
                    nbits++;
                end
                busy_until = cyc + nbits * C;
            end
            if (do_push) mq.push_back(tx_data);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit valid, input logic [7:0] data,
                                 input logic [1:0] mode, input bit stop2);
        tx_valid    = valid;
        tx_data     = data;
        parity_mode = mode;
        two_stop    = stop2;
    endtask

    task automatic step();
        @(negedge clk);
        checkOutput("txd", int'(uart_txd), int'(exp_txd));
        checkOutput("fifo_count", int'(fifo_count), mq.size());
        checkOutput("tx_ready", int'(tx_ready), int'(mq.size() != DEPTH));
        checkOutput("busy", int'(uart_tx_busy), int'((mq.size() > 0) || (cyc < busy_until)));
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((uart_tx_busy !== 1'b0 || uart_txd !== 1'b1) && n < 3000) begin
            step();
            n++;
        end
        repeat (3) step();
        checkOutput("idle reached", int'(n < 3000), 1);
    endtask

    task automatic waitLevel(input string name, input bit wide, input bit level, input int bound);
        int n = 0;
        while (((wide ? txd9 : uart_txd) !== level) && n < bound) begin
            step();
            n++;
        end
        checkOutput(name, int'(n < bound), 1);
    endtask

    task automatic measureRun(input bit wide, input bit level, input int bound, output int len);
        len = 0;
        while (((wide ? txd9 : uart_txd) === level) && len < bound) begin
            len++;
            step();
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [1:0] mode;
        logic       stop2;
        string      bits;
    } vec_t;

    vec_t vecs[6];

    task automatic runVector(input vec_t v, input int idx);
        int lat;
        int held;
        waitIdle();
        applyStimulus(1'b1, v.data, v.mode, v.stop2);
        step();
        applyStimulus(1'b0, v.data, v.mode, v.stop2);
        lat = 0;
        while (uart_txd !== 1'b0 && lat < 50) begin
            step();
            lat++;
        end
        checkOutput($sformatf("vec%0d start latency", idx), lat, 3);
        for (int k = 0; k < v.bits.len(); k++) begin
            held = 0;
            for (int j = 0; j < C; j++) begin
                if (uart_txd === (v.bits[k] == "1")) held++;
                step();
            end
            checkOutput($sformatf("vec%0d bit%0d held", idx, k), held, C);
        end
        checkOutput($sformatf("vec%0d line idle", idx), int'(uart_txd), 1);
        checkOutput($sformatf("vec%0d busy dropped", idx), int'(uart_tx_busy), 0);
    endtask

    initial begin
        int  acc;
        int  max_cnt;
        bit  saw_low;
        bit  rdy;
        int  n;
        int  r;
        int  lows;
        int  dens;

        vecs[0] = '{8'hA5, 2'b00, 1'b0, "0101001011"};
        vecs[1] = '{8'h07, 2'b01, 1'b0, "01110000011"};
        vecs[2] = '{8'h07, 2'b10, 1'b0, "01110000001"};
        vecs[3] = '{8'h3C, 2'b00, 1'b1, "00011110011"};
        vecs[4] = '{8'h80, 2'b10, 1'b1, "000000001011"};
        vecs[5] = '{8'h5A, 2'b01, 1'b1, "001011010011"};

        reset     = 1'b1;
        tx_data9  = '0;
        tx_valid9 = 1'b0;
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
        repeat (3) step();
        checkOutput("reset txd", int'(uart_txd), 1);
        checkOutput("reset tx_ready", int'(tx_ready), 1);
        checkOutput("reset fifo_count", int'(fifo_count), 0);
        checkOutput("reset busy", int'(uart_tx_busy), 0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) runVector(vecs[i], i);

        // Burst: valid held high through backpressure, frames must stay in order
        waitIdle();
        acc = 0; max_cnt = 0; saw_low = 0; n = 0;
        while (acc < 6 && n < 2000) begin
            applyStimulus(1'b1, 8'(acc + 1), 2'b00, 1'b0);
            rdy = tx_ready;
            if (!rdy) saw_low = 1'b1;
            step();
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (rdy) acc++;
            n++;
        end
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
        checkOutput("burst words accepted", acc, 6);
        checkOutput("burst max fifo_count", max_cnt, DEPTH);
        checkOutput("burst ready low seen", int'(saw_low), 1);
        waitIdle();

        // Two stop bits kept for the frame in flight when two_stop is cleared
        applyStimulus(1'b1, 8'h00, 2'b00, 1'b1);
        step();
        applyStimulus(1'b1, 8'h00, 2'b00, 1'b1);
        step();
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
        waitLevel("two_stop frame1 start", 1'b0, 1'b0, 20);
        measureRun(1'b0, 1'b0, 200, r);
        checkOutput("two_stop frame1 low run", r, 9 * C);
        measureRun(1'b0, 1'b1, 200, r);
        checkOutput("two_stop gap", r, 2 * C);
        measureRun(1'b0, 1'b0, 200, r);
        checkOutput("two_stop frame2 low run", r, 9 * C);
        measureRun(1'b0, 1'b1, C, r);
        checkOutput("frame2 one stop busy", int'(uart_tx_busy), 0);
        waitIdle();

        // Reset in data bit 3 with two words queued
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(i * 17), 2'b00, 1'b0);
            step();
        end
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
        waitLevel("reset test frame start", 1'b0, 1'b0, 20);
        repeat (44) step();
        checkOutput("pre-reset fifo_count", int'(fifo_count), 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("post-reset txd", int'(uart_txd), 1);
        checkOutput("post-reset fifo_count", int'(fifo_count), 0);
        checkOutput("post-reset tx_ready", int'(tx_ready), 1);
        checkOutput("post-reset busy", int'(uart_tx_busy), 0);
        lows = 0;
        repeat (300) begin
            step();
            if (uart_txd !== 1'b1) lows++;
        end
        checkOutput("post-reset line quiet", lows, 0);

        // Default bit rate, 9 data bits: 0x0AA gives merged start+b0, 7 single bits, b8 low
        tx_data9  = 9'h0AA;
        tx_valid9 = 1'b1;
        step();
        tx_valid9 = 1'b0;
        waitLevel("wide frame start", 1'b1, 1'b0, 10);
        for (int i = 0; i < 9; i++) begin
            measureRun(1'b1, 1'(i % 2), 2000, r);
            checkOutput($sformatf("wide run%0d", i), r, (i == 0) ? 868 : 434);
        end
        measureRun(1'b1, 1'b1, 500, r);
        checkOutput("wide stop and idle", r, 500);

        // Randomised traffic with configuration changes and occasional resets
        for (int i = 0; i < 4000; i++) begin
            dens = (i < 2000) ? 30 : 3;
            applyStimulus($urandom_range(0, 99) < dens, 8'($urandom),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            reset = ($urandom_range(0, 1499) == 0);
            step();
        end
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00, 2'b00, 1'b0);
        waitIdle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an internal transmit FIFO, runtime-selectable parity and one or two stop bits. Accepts payload words over a valid/ready handshake, buffers up to FIFO_DEPTH words, and serialises them LSB-first onto uart_txd with back-to-back frames. It is the next-generation transmit path for the board's serial link to the host, and tolerates bursty producers.

Parameters:
PAYLOAD_BITS, 8, data bits per frame; legal range 5..9.
CLK_HZ, 50_000_000, system clock frequency in Hz.
BIT_RATE, 115200, line bit rate in bits/s.
FIFO_DEPTH, 4, words of buffering; power of two, >= 2.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
uart_txd  output  1  serial line, registered; idles high.
tx_data  input  PAYLOAD_BITS  word to enqueue.
tx_valid  input  1  producer offers tx_data.
tx_ready  output  1  FIFO can accept; high when not full.
parity_mode  input  2  00 none, 01 even, 10 odd, 11 none.
two_stop  input  1  0 = 1 stop bit, 1 = 2 stop bits.
fifo_count  output  $clog2(FIFO_DEPTH+1)  words currently buffered.
uart_tx_busy  output  1  high while a frame is on the line or FIFO non-empty.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Bit timing: CYCLES_PER_BIT = CLK_HZ / BIT_RATE, integer division in Hz with no ns intermediate. Every line bit holds exactly CYCLES_PER_BIT cycles. The cycle counter is $clog2(CYCLES_PER_BIT+1) bits wide and counts 0..CYCLES_PER_BIT-1.
- Reset: uart_txd=1, tx_ready=1, fifo_count=0, uart_tx_busy=0. FIFO pointers are cleared and the FSM goes to IDLE.
- Reset mid-frame: the frame is aborted and all buffered words are discarded. uart_txd is 1 on the cycle after reset is sampled.
- Handshake: a write occurs on a clk edge with tx_valid && tx_ready.
  - tx_ready = (fifo_count != FIFO_DEPTH). tx_valid while full is ignored; no overwrite.
  - Simultaneous push and pop while full: the pop frees a slot only on the following cycle, so tx_ready stays low that cycle. fifo_count is unchanged by a simultaneous push and pop.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when the FIFO is non-empty. This pops the head word into the shift register, latches parity_mode and two_stop, and computes parity (even: XOR of data; odd: its inverse).
  - START: line 0 for one bit period -> DATA.
  - DATA: PAYLOAD_BITS bit periods, LSB first. Then PARITY if the latched mode is 01/10, else STOP.
  - PARITY: one bit period -> STOP.
  - STOP: line 1 for 1 or 2 bit periods per the latched two_stop. At the end of the last stop period: START if the FIFO is non-empty (pop the same cycle, no extra idle bit), else IDLE.
- Configuration changes: parity_mode and two_stop changes mid-frame do not affect the current frame.
- Latency: a write into an empty FIFO with the FSM in IDLE drives uart_txd low exactly 3 clk edges after the write edge.
- uart_tx_busy = (state != IDLE) || (fifo_count != 0).
- Empty FIFO: no pop is ever attempted. Read/write pointers wrap modulo FIFO_DEPTH.

Test Plan:
Use CLK_HZ=1_000_000 and BIT_RATE=100_000, giving 10 cycles/bit, unless noted.

1. Reset, then write 0xA5 with parity 00 and two_stop 0 -> line reads 0,1,0,1,0,0,1,0,1,1, each level held 10 cycles; falling edge 3 cycles after the write; busy drops after the stop bit.
2. Write 0x07 with parity 01 (even) -> parity bit 1; then 0x07 with parity 10 (odd) -> parity bit 0; frame length 11 bits.
3. Hold tx_valid high with words 0x01..0x06 while the line is busy -> tx_ready drops once fifo_count=4; exactly 4 words are accepted plus refills as frames pop; all frames go out in order with no idle gap between stop and the next start.
4. two_stop=1 -> the line stays high for 20 cycles between consecutive frames; toggling two_stop mid-frame leaves the current frame at 2 stop bits.
5. Assert reset during the DATA bit 3 of a frame with 2 words queued -> uart_txd=1 next cycle, fifo_count=0, tx_ready=1, no further frames emitted.
6. Defaults (50 MHz, 115200) -> every bit period measures 434 cycles; PAYLOAD_BITS=9 build sends 9 data bits per frame.
